// File: rtl/life_gen_sequencer.sv
// life_gen_sequencer: owns a double-buffered 16x16 toroidal Game of Life board.
// The display bank is read combinationally by the VGA path. A generation is
// computed row by row into the shadow bank. The banks are swapped only while
// vblank is high, so a frame never shows a half-updated board.
//
// Handshake / pulse semantics: run and vblank are levels. step_tick,
// single_step and seed_load are one-cycle pulses sampled on the rising edge
// of board_clk. A pulse that the block cannot act on is dropped; it is never
// queued. A step request that arrives while busy also sets the sticky overrun
// flag.
module life_gen_sequencer #(
    parameter int ROWS  = 16,
    parameter int GEN_W = 16
) (
    input  logic             board_clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step_tick,
    input  logic             single_step,
    input  logic             vblank,
    input  logic             seed_load,
    input  logic             wr_en,
    input  logic [3:0]       wr_x,
    input  logic [3:0]       wr_y,
    input  logic             wr_val,
    input  logic [3:0]       rd_x,
    input  logic [3:0]       rd_y,
    output logic             rd_alive,
    output logic             busy,
    output logic [1:0]       state,
    output logic [GEN_W-1:0] gen_count,
    output logic             overrun
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_LOAD      = 2'b01,
        ST_COMPUTE   = 2'b10,
        ST_WAIT_SWAP = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       row_q, row_d;
    logic             bank_sel_q, bank_sel_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             overrun_q, overrun_d;
    logic [15:0]      bank0_q [ROWS];
    logic [15:0]      bank0_d [ROWS];
    logic [15:0]      bank1_q [ROWS];
    logic [15:0]      bank1_d [ROWS];

    logic             step_req;
    logic [3:0]       row_up;
    logic [3:0]       row_dn;
    logic [15:0]      disp_up;
    logic [15:0]      disp_cur;
    logic [15:0]      disp_dn;
    logic [15:0]      new_row;

    // Next state of one board row from its three display-bank neighbours,
    // with columns wrapping around (column -1 is 15, column 16 is 0).
    function automatic logic [15:0] life_row(input logic [15:0] up,
                                             input logic [15:0] cur,
                                             input logic [15:0] dn);
        logic [15:0] res;
        logic [3:0]  ci;
        logic [3:0]  li;
        logic [3:0]  ri;
        logic [3:0]  n;
        res = '0;
        for (int c = 0; c < 16; c++) begin
            ci = 4'(c);
            li = ci - 4'd1;
            ri = ci + 4'd1;
            n  = 4'(up[li]) + 4'(up[ci]) + 4'(up[ri])
               + 4'(cur[li])              + 4'(cur[ri])
               + 4'(dn[li]) + 4'(dn[ci]) + 4'(dn[ri]);
            res[ci] = (n == 4'd3) | (cur[ci] & (n == 4'd2));
        end
        return res;
    endfunction

    assign step_req = (run & step_tick) | single_step;

    // The row counter wraps naturally in 4 bits, which gives the toroidal rows.
    assign row_up   = row_q - 4'd1;
    assign row_dn   = row_q + 4'd1;
    assign disp_up  = bank_sel_q ? bank1_q[row_up] : bank0_q[row_up];
    assign disp_cur = bank_sel_q ? bank1_q[row_q]  : bank0_q[row_q];
    assign disp_dn  = bank_sel_q ? bank1_q[row_dn] : bank0_q[row_dn];
    assign new_row  = life_row(disp_up, disp_cur, disp_dn);

    // Sequencer next-state, including bank writes for edit, seed and compute.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        bank_sel_d = bank_sel_q;
        gen_d      = gen_q;
        overrun_d  = overrun_q;
        bank0_d    = bank0_q;
        bank1_d    = bank1_q;

        unique case (state_q)
            ST_IDLE: begin
                if (seed_load) begin
                    // The seed wins over a simultaneous step; that step is dropped quietly.
                    state_d   = ST_LOAD;
                    overrun_d = 1'b0;
                end else if (step_req) begin
                    state_d = ST_COMPUTE;
                    row_d   = 4'd0;
                end else if (wr_en) begin
                    if (bank_sel_q) bank1_d[wr_y][wr_x] = wr_val;
                    else            bank0_d[wr_y][wr_x] = wr_val;
                end
            end

            ST_LOAD: begin
                for (int r = 0; r < ROWS; r++) begin
                    if (bank_sel_q) bank1_d[r] = '0;
                    else            bank0_d[r] = '0;
                end
                // Glider: (1,0), (2,1), (0,2), (1,2), (2,2).
                if (bank_sel_q) begin
                    bank1_d[0] = 16'h0002;
                    bank1_d[1] = 16'h0004;
                    bank1_d[2] = 16'h0007;
                end else begin
                    bank0_d[0] = 16'h0002;
                    bank0_d[1] = 16'h0004;
                    bank0_d[2] = 16'h0007;
                end
                gen_d   = '0;
                state_d = ST_IDLE;
                if (step_req) overrun_d = 1'b1;
            end

            ST_COMPUTE: begin
                // Results go to the shadow bank, which is the bank not on display.
                if (bank_sel_q) bank0_d[row_q] = new_row;
                else            bank1_d[row_q] = new_row;
                row_d = row_q + 4'd1;
                if (row_q == 4'd15) state_d = ST_WAIT_SWAP;
                if (step_req) overrun_d = 1'b1;
            end

            ST_WAIT_SWAP: begin
                if (vblank) begin
                    bank_sel_d = ~bank_sel_q;
                    gen_d      = gen_q + 1'b1;
                    state_d    = ST_IDLE;
                end
                if (step_req) overrun_d = 1'b1;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // All sequencer state and both banks; reset discards any partial generation.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            row_q      <= 4'd0;
            bank_sel_q <= 1'b0;
            gen_q      <= '0;
            overrun_q  <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                bank0_q[r] <= '0;
                bank1_q[r] <= '0;
            end
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            bank_sel_q <= bank_sel_d;
            gen_q      <= gen_d;
            overrun_q  <= overrun_d;
            bank0_q    <= bank0_d;
            bank1_q    <= bank1_d;
        end
    end

    assign rd_alive  = bank_sel_q ? bank1_q[rd_y][rd_x] : bank0_q[rd_y][rd_x];
    assign state     = state_q;
    assign busy      = (state_q != ST_IDLE);
    assign gen_count = gen_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/life_gen_sequencer.md
Name: life_gen_sequencer

Overview:
Owns the 16x16 Game of Life board and sequences generation updates for the VGA display path.
- Board is double-buffered: a display bank and a shadow bank.
- The VGA pixel logic reads cells from the display bank combinationally.
- Per generation, the block computes the next board row by row into the shadow bank, then swaps banks only during vertical blank, so no frame shows a torn board.
- Also provides seed loading and single-cell editing while idle.

Parameters:
ROWS, 16, board height; also board width (square, toroidal)
GEN_W, 16, width of generation counter

Ports:
board_clk  in  1  system clock
reset  in  1  asynchronous, active-high; clock board_clk
run  in  1  level; enables free-running generations on step_tick
step_tick  in  1  one-cycle pulse, generation rate
single_step  in  1  one-cycle pulse; one generation regardless of run
vblank  in  1  level; high while safe to swap banks
seed_load  in  1  one-cycle pulse; load glider seed into display bank
wr_en  in  1  cell write strobe into display bank
wr_x  in  4  write column
wr_y  in  4  write row
wr_val  in  1  write value
rd_x  in  4  read column (from VGA x)
rd_y  in  4  read row (from VGA y)
rd_alive  out  1  display-bank cell (rd_x, rd_y), combinational
busy  out  1  high in LOAD, COMPUTE, WAIT_SWAP
state  out  2  00 IDLE, 01 LOAD, 10 COMPUTE, 11 WAIT_SWAP
gen_count  out  GEN_W  completed generations
overrun  out  1  sticky: a step request arrived while busy

Behaviour:
- Storage: each bank is ROWS rows of 16 bits; bit c of row r is cell (x=c, y=r). bank_sel selects the display bank.
- Reset: both banks all zero, bank_sel=0, state IDLE, gen_count=0, overrun=0, row counter 0. rd_alive=0.
- Step request: (run & step_tick) | single_step.
- IDLE, priority order:
  - seed_load -> LOAD.
  - Else step request -> COMPUTE with row counter 0.
  - Else wr_en writes wr_val to the display bank at (wr_x, wr_y), visible on rd_alive the next cycle.
- LOAD: one cycle.
  - Display bank cleared except glider: (1,0), (2,1), (0,2), (1,2), (2,2).
  - gen_count <- 0; overrun unchanged; -> IDLE.
- COMPUTE: 16 cycles.
  - Cycle k computes shadow row k from display rows (k-1) mod 16, k, (k+1) mod 16.
  - Columns are also toroidal: column -1 = 15, column 16 = 0.
  - Rule per cell: n = count of 8 neighbours (3-bit sum saturates not needed, max 8 uses 4 bits). Next = (n==3) | (alive & n==2).
  - After row 15 -> WAIT_SWAP.
- WAIT_SWAP: on the first edge with vblank=1, bank_sel toggles, gen_count increments, and state -> IDLE. If vblank is already high on entry, the swap occurs on that first WAIT_SWAP edge.
- gen_count wraps from all-ones to 0.
- Latency: request sampled at edge T gives COMPUTE at T+1..T+16, WAIT_SWAP from T+17, and earliest swap at edge T+17. rd_alive shows the new generation from T+17 onward.
- While busy: step requests are dropped and set overrun. seed_load and wr_en are ignored; they do not set overrun.
- overrun clears only on reset or seed_load.
- run deasserted mid-generation: the current generation completes normally; no further step_tick requests are accepted.
- Simultaneous seed_load and step request in IDLE: seed_load wins; the step is dropped without setting overrun.
- Reset asserted mid-COMPUTE or mid-WAIT_SWAP: immediate return to reset values; the partial shadow bank is discarded.
- rd_alive is pure combinational from the display bank; the shadow bank is never visible.

Test Plan:
- Reset: assert reset mid-COMPUTE -> state=00, busy=0, gen_count=0, rd_alive=0 at all 256 (x,y), overrun=0.
- Blinker: write (4,5), (5,5), (6,5); single_step with vblank=1 -> busy for 17 cycles, then cells (5,4), (5,5), (5,6) alive and all others dead; gen_count=1. Step again -> original pattern returns; gen_count=2.
- Toroidal wrap: write (15,0), (0,0), (1,0); single_step -> alive exactly (0,15), (0,0), (0,1).
- Swap hold: vblank=0 during step -> state stays 11 and rd_alive shows the old board for 100 cycles. Raise vblank -> swap next edge, state 00.
- Glider: seed_load, run=1, four step_ticks spaced 40 cycles apart, vblank=1 -> glider translated by (+1,+1): alive (2,1), (3,2), (1,3), (2,3), (3,3); gen_count=4.
- Overrun and priority: step_tick during COMPUTE -> overrun=1, gen_count advances by 1 only. seed_load together with single_step in IDLE -> LOAD taken, overrun=0, gen_count=0.
